store_merge_unit: RTL and testbench

- Store-path narrowing unit between the datapath's store stage and a word-only data memory.
- Takes a store of byte (sb), halfword (sh) or word (sw) size and places the narrowed data into the correct byte lanes.
- The memory has no byte enables, so sub-word stores are done as read-modify-write: read word, merge lanes, write word back.
- Stalls the pipeline through its handshake until the memory write has been issued.

---
 rtl/store_merge_unit.sv | 114 +++++++++++
 tb/tb_store_merge_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Store narrowing unit: places sb/sh/sw data into the right byte lanes of a
// word-only memory, doing read-modify-write for sub-word stores.
module store_merge_unit #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   input  logic [1:0]    st_size,
   output logic          st_done,
   output logic          st_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_wr,
   output logic [DW-1:0] mem_wdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_MERGE,
      S_WRITE,
      S_ERR
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   state_t          r_state;
   state_t          w_state_next;
   logic [AW-1:0]   r_addr;
   logic [15:0]     r_data;
   logic [1:0]      r_size;
   logic [DW-1:0]   r_wdata;
   logic [DW-1:0]   w_merged;
   logic            w_misaligned;
   logic            w_accept;

   assign w_accept     = (r_state == S_IDLE) && st_valid;
   assign w_misaligned = (st_size == SZ_RSVD) ||
                         ((st_size == SZ_HALF) && st_addr[0]) ||
                         ((st_size == SZ_WORD) && (st_addr[1:0] != 2'b00));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (st_valid) begin
               if (w_misaligned)
                  w_state_next = S_ERR;
               else if (st_size == SZ_WORD)
                  w_state_next = S_WRITE;
               else
                  w_state_next = S_READ;
            end
         end
         S_READ:  w_state_next = S_MERGE;
         S_MERGE: w_state_next = S_WRITE;
         S_WRITE: w_state_next = S_IDLE;
         S_ERR:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Per-lane merge: a lane takes store data when selected, else the memory byte.
   // Half stores feed the even lane from data[7:0] and the odd lane from data[15:8].
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic w_sel;
         logic [7:0] w_src;
         assign w_sel = (r_size == SZ_BYTE) ? (r_addr[1:0] == LANE) : (r_addr[1] == LANE[1]);
         assign w_src = ((r_size == SZ_BYTE) || !LANE[0]) ? r_data[7:0] : r_data[15:8];
         assign w_merged[gi*8 +: 8] = w_sel ? w_src : mem_rdata[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_data  <= '0;
         r_size  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_addr  <= st_addr;
            r_data  <= st_data[15:0];
            r_size  <= st_size;
            r_wdata <= st_data;
         end else if (r_state == S_MERGE) begin
            r_wdata <= w_merged;
         end
      end
   end

   assign st_ready  = (r_state == S_IDLE);
   assign mem_rd    = (r_state == S_READ);
   assign mem_wr    = (r_state == S_WRITE);
   assign st_done   = (r_state == S_WRITE);
   assign st_err    = (r_state == S_ERR);
   assign mem_addr  = ((r_state == S_READ) || (r_state == S_MERGE) || (r_state == S_WRITE)) ?
                      {r_addr[AW-1:2], 2'b00} : '0;
   assign mem_wdata = (r_state == S_WRITE) ? r_wdata : '0;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: directed cases then random stores, checked
// against a byte-addressed reference memory.
module tb_store_merge_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic [1:0]  st_size = '0;
   logic        st_done;
   logic        st_err;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata = '0;
   logic        mem_wr;
   logic [31:0] mem_wdata;

   store_merge_unit #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
      .st_done(st_done), .st_err(st_err),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata)
   );

   always #5 clk = ~clk;

   // Word memory with synchronous read; garbage on rdata when not reading.
   logic [31:0] mem [64];
   logic        load_en = 1'b0;
   int          load_idx = 0;
   logic [31:0] load_val = '0;
   int          cyc_cnt = 0;
   int          wr_total = 0;
   int          overlap = 0;

   always @(posedge clk) begin
      cyc_cnt  <= cyc_cnt + 1;
      wr_total <= wr_total + (mem_wr ? 1 : 0);
      if (mem_rd && mem_wr) overlap <= overlap + 1;
      if (load_en) mem[load_idx] <= load_val;
      else if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr[7:2]];
      else mem_rdata <= $urandom;
   end

   // Reference: plain byte array, little-endian
   logic [7:0]  ref_b [256];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] last_wdata;

   function automatic logic [31:0] ref_word(input int wi);
      return {ref_b[4*wi+3], ref_b[4*wi+2], ref_b[4*wi+1], ref_b[4*wi]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      for (int k = 0; k < 4; k++) ref_b[4*idx+k] = v[8*k +: 8];
      load_idx = idx;
      load_val = v;
      load_en  = 1'b1;
      @(negedge clk);
      load_en  = 1'b0;
   endtask

   // Issue one store at a negedge and watch six cycles after the accept edge.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      int w, rd_n, wr_n, err_n, done_n, rd_c, wr_c, err_c, done_c, nb;
      logic [31:0] rd_a, wr_a, wr_d, exp_w;
      logic bad;
      w = 0;
      while (!st_ready && w < 20) begin @(negedge clk); w++; end
      chk("ready_before_req", 32'(st_ready), 32'd1);
      st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
      @(negedge clk);
      st_valid = 1'b0;
      rd_n = 0; wr_n = 0; err_n = 0; done_n = 0;
      rd_c = 0; wr_c = 0; err_c = 0; done_c = 0;
      rd_a = '0; wr_a = '0; wr_d = '0;
      for (int c = 1; c <= 6; c++) begin
         if (mem_rd)   begin rd_n++;  rd_c = c; rd_a = mem_addr; end
         if (mem_wr)   begin wr_n++;  wr_c = c; wr_a = mem_addr; wr_d = mem_wdata; end
         if (st_err)   begin err_n++; err_c = c; end
         if (st_done)  begin done_n++; done_c = c; end
         if (c < 6) @(negedge clk);
      end
      last_wdata = wr_d;
      bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      if (bad) begin
         chk("err_count", err_n, 1);
         chk("err_latency", err_c, 1);
         chk("err_no_rd", rd_n, 0);
         chk("err_no_wr", wr_n, 0);
         chk("err_no_done", done_n, 0);
      end else begin
         nb = 1 << sz;
         for (int k = 0; k < nb; k++) ref_b[(a + k) & 255] = d[8*k +: 8];
         exp_w = ref_word(int'(a[7:2]));
         chk("no_err", err_n, 0);
         chk("wr_count", wr_n, 1);
         chk("done_count", done_n, 1);
         chk("wr_addr", wr_a, {a[31:2], 2'b00});
         chk("wr_data", wr_d, exp_w);
         if (sz == 2'b10) begin
            chk("sw_latency", wr_c, 1);
            chk("sw_done_latency", done_c, 1);
            chk("sw_no_rd", rd_n, 0);
         end else begin
            chk("rd_count", rd_n, 1);
            chk("rd_latency", rd_c, 1);
            chk("rd_addr", rd_a, {a[31:2], 2'b00});
            chk("sub_latency", wr_c, 3);
            chk("sub_done_latency", done_c, 3);
         end
      end
      $display("store addr=%h data=%h size=%0d -> rd=%0d wr=%0d@%0d err=%0d wdata=%h",
               a, d, sz, rd_n, wr_n, wr_c, err_n, wr_d);
   endtask

   initial begin
      int acc [4];
      int w, wr_before;
      logic [31:0] a, d;
      logic [1:0] sz;

      #1;
      chk("rst_st_ready", 32'(st_ready), 32'd1);
      chk("rst_st_done", 32'(st_done), 32'd0);
      chk("rst_st_err", 32'(st_err), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) set_word(i, $urandom);

      // Reset during MERGE abandons the sub-word store
      set_word(16, 32'hA5A5A5A5);
      st_valid = 1'b1; st_addr = 32'h41; st_data = 32'h99; st_size = 2'b00;
      @(negedge clk);
      st_valid = 1'b0;
      @(negedge clk);
      chk("merge_busy", 32'(st_ready), 32'd0);
      wr_before = wr_total;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(st_ready), 32'd1);
      chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
      chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
      chk("midrst_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_no_write", wr_total, wr_before);
      chk("midrst_mem_kept", mem[16], 32'hA5A5A5A5);

      // Directed cases
      do_store(32'h10, 32'hDEADBEEF, 2'b10);
      chk("sw_lit", last_wdata, 32'hDEADBEEF);
      set_word(8, 32'h11223344);
      do_store(32'h22, 32'h000000AB, 2'b00);
      chk("sb_lit", last_wdata, 32'h11AB3344);
      set_word(8, 32'h11223344);
      do_store(32'h22, 32'hFFFFCAFE, 2'b01);
      chk("sh_hi_lit", last_wdata, 32'hCAFE3344);
      set_word(8, 32'h11223344);
      do_store(32'h20, 32'hFFFFCAFE, 2'b01);
      chk("sh_lo_lit", last_wdata, 32'h1122CAFE);
      do_store(32'h23, 32'h1234, 2'b01);
      do_store(32'h12, 32'h1234, 2'b10);
      do_store(32'h20, 32'h1234, 2'b11);

      // Back-to-back byte stores with st_valid held high
      set_word(0, 32'h0);
      st_valid = 1'b1;
      st_size = 2'b00;
      for (int k = 0; k < 4; k++) begin
         st_addr = 32'(k);
         st_data = 32'((k + 1) * 32'h11);
         w = 0;
         while (!st_ready && w < 20) begin @(negedge clk); w++; end
         chk("b2b_ready", 32'(st_ready), 32'd1);
         acc[k] = cyc_cnt + 1;
         ref_b[k] = st_data[7:0];
         @(negedge clk);
         $display("b2b accept %0d at cycle %0d", k, acc[k]);
      end
      st_valid = 1'b0;
      repeat (5) @(negedge clk);
      for (int k = 1; k < 4; k++) chk("b2b_spacing", acc[k] - acc[k-1], 4);
      chk("b2b_word", mem[0], 32'h44332211);

      // Random stores, mostly aligned, some misaligned/reserved
      for (int n = 0; n < 40; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 255));
         d  = $urandom;
         if (sz == 2'b10 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         if (sz == 2'b01 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
         do_store(a, d, sz);
      end

      for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(i));
      chk("rd_wr_overlap", overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
